slot_controller: RTL and testbench

Sequencing controller for the three-reel slot machine datapath. It conditions the two raw push-buttons, gates each reel's run enable, and stops the reels one at a time at a fixed spacing. Once all reels are stopped it compares the three reel digits and keeps a credit balance. It sits between the board buttons and the per-reel clock-divider/slot instances and replaces the ad-hoc state logic in the top level.

---
 rtl/slot_pkg.sv | 29 ++
 rtl/button_sync.sv | 28 ++
 rtl/slot_controller.sv | 170 +++++++++++++++++
 tb/tb_slot_controller.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// Shared types for the slot machine sequencing controller.
// Holds FSM state encoding, reel/credit types and credit arithmetic.
package slot_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPIN,
        S_STOP,
        S_EVAL,
        S_SHOW
    } state_t;

    localparam int NUM_REELS = 3;

    typedef logic [3:0] digit_t;
    typedef logic [6:0] credit_t;

    // Add with an 8-bit intermediate so the carry is visible, then clamp.
    function automatic credit_t credit_add(
        credit_t    c,
        logic [7:0] add,
        logic [7:0] lim
    );
        logic [7:0] s;
        s = {1'b0, c} + add;
        return (s > lim) ? lim[6:0] : s[6:0];
    endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchronizer plus rising-edge detector for a raw button.
// Ports: clk, rst_n (async active-low), i_btn raw input, o_press one-cycle pulse.
module button_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_btn;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_press = r_sync & ~r_prev;

endmodule

// File: rtl/slot_controller.sv
// Slot machine sequencer: button conditioning, reel run gating, staggered stops,
// three-of-a-kind evaluation and a saturating credit balance.
// Ports: clk, rst_n, btn_spin, btn_set, digit[0:2] in; reel_run, reel_clr,
// credits, win, busy out (all registered).
module slot_controller
    import slot_pkg::*;
#(
    parameter int STOP_GAP    = 16,
    parameter int MIN_SPIN    = 8,
    parameter int CREDIT_INIT = 5,
    parameter int CREDIT_MAX  = 99,
    parameter int WIN_PAYOUT  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_spin,
    input  logic                 btn_set,
    input  digit_t               digit [0:NUM_REELS-1],
    output logic [NUM_REELS-1:0] reel_run,
    output logic                 reel_clr,
    output credit_t              credits,
    output logic                 win,
    output logic                 busy
);

    localparam int SW = $clog2(MIN_SPIN + 1);
    localparam int GW = $clog2(STOP_GAP + 1);
    localparam logic [SW-1:0] SPIN_END = SW'(MIN_SPIN);
    localparam logic [GW-1:0] GAP_END  = GW'(STOP_GAP - 1);

    logic w_spin_press;
    logic w_set_press;

    button_sync u_sync_spin (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_spin),
        .o_press (w_spin_press)
    );

    button_sync u_sync_set (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_btn   (btn_set),
        .o_press (w_set_press)
    );

    state_t                r_state;
    logic [SW-1:0]         r_spin_cnt;
    logic [GW-1:0]         r_gap_cnt;
    logic [NUM_REELS-1:0]  r_run;
    logic                  r_clr;
    credit_t               r_cred;
    logic                  r_win;
    logic                  r_busy;

    state_t                w_state_nxt;
    logic [SW-1:0]         w_spin_nxt;
    logic [GW-1:0]         w_gap_nxt;
    logic [NUM_REELS-1:0]  w_run_nxt;
    logic                  w_clr_nxt;
    credit_t               w_cred_nxt;
    logic                  w_win_nxt;
    logic                  w_busy_nxt;
    logic                  w_can_spin;
    logic                  w_match;

    assign w_can_spin = w_spin_press && (r_cred != '0);
    assign w_match    = (digit[0] == digit[1]) && (digit[1] == digit[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_spin_cnt <= '0;
            r_gap_cnt  <= '0;
            r_run      <= '0;
            r_clr      <= 1'b0;
            r_cred     <= credit_t'(CREDIT_INIT);
            r_win      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_spin_cnt <= w_spin_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_run      <= w_run_nxt;
            r_clr      <= w_clr_nxt;
            r_cred     <= w_cred_nxt;
            r_win      <= w_win_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_spin_nxt  = r_spin_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_run_nxt   = r_run;
        w_clr_nxt   = 1'b0;
        w_cred_nxt  = r_cred;
        w_win_nxt   = r_win;
        w_busy_nxt  = r_busy;

        if (w_set_press) begin
            // Abort wins over any spin press arriving in the same cycle.
            w_state_nxt = S_IDLE;
            w_spin_nxt  = '0;
            w_gap_nxt   = '0;
            w_run_nxt   = '0;
            w_clr_nxt   = 1'b1;
            w_cred_nxt  = credit_t'(CREDIT_INIT);
            w_win_nxt   = 1'b0;
            w_busy_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_SHOW: begin
                    if (w_can_spin) begin
                        w_state_nxt = S_SPIN;
                        w_spin_nxt  = '0;
                        w_run_nxt   = '1;
                        w_cred_nxt  = r_cred - credit_t'(1);
                        w_win_nxt   = 1'b0;
                        w_busy_nxt  = 1'b1;
                    end
                end
                S_SPIN: begin
                    if (w_spin_press && (r_spin_cnt == SPIN_END)) begin
                        w_state_nxt  = S_STOP;
                        w_gap_nxt    = '0;
                        w_run_nxt[0] = 1'b0;
                    end else if (r_spin_cnt != SPIN_END) begin
                        w_spin_nxt = r_spin_cnt + SW'(1);
                    end
                end
                S_STOP: begin
                    if (r_gap_cnt == GAP_END) begin
                        w_gap_nxt = '0;
                        // Reels stop in order, so a live bit 1 means it goes next.
                        if (r_run[1]) begin
                            w_run_nxt[1] = 1'b0;
                        end else begin
                            w_run_nxt[2] = 1'b0;
                            w_state_nxt  = S_EVAL;
                        end
                    end else begin
                        w_gap_nxt = r_gap_cnt + GW'(1);
                    end
                end
                S_EVAL: begin
                    w_state_nxt = S_SHOW;
                    w_busy_nxt  = 1'b0;
                    w_win_nxt   = w_match;
                    if (w_match) begin
                        w_cred_nxt = credit_add(r_cred, 8'(WIN_PAYOUT),
                                                8'(CREDIT_MAX));
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign reel_run = r_run;
    assign reel_clr = r_clr;
    assign credits  = r_cred;
    assign win      = r_win;
    assign busy     = r_busy;

endmodule

// File: tb/tb_slot_controller.sv
// Self-checking bench for slot_controller: vector table, corner sequences,
// and randomized button traffic against a timing-level reference model.
module tb_slot_controller;
    import slot_pkg::*;

    localparam int G    = 16;
    localparam int MS   = 8;
    localparam int CI   = 5;
    localparam int CM   = 99;
    localparam int WP   = 10;
    localparam int CM12 = 12;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    logic    btn_spin = 1'b0;
    logic    btn_set = 1'b0;
    digit_t  digit [0:2];

    logic [2:0] run_a, run_b;
    logic       clr_a, clr_b;
    credit_t    cred_a, cred_b;
    logic       win_a, win_b;
    logic       busy_a, busy_b;

    slot_controller dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_spin (btn_spin),
        .btn_set  (btn_set),
        .digit    (digit),
        .reel_run (run_a),
        .reel_clr (clr_a),
        .credits  (cred_a),
        .win      (win_a),
        .busy     (busy_a)
    );

    slot_controller #(.CREDIT_MAX(CM12)) dut_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_spin (btn_spin),
        .btn_set  (btn_set),
        .digit    (digit),
        .reel_run (run_b),
        .reel_clr (clr_b),
        .credits  (cred_b),
        .win      (win_b),
        .busy     (busy_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a spin is described by the edge it started on and
    // the edge its stop was accepted on; everything else is arithmetic.
    int       m_e;
    bit [3:0] m_sh_spin, m_sh_set;
    bit       m_clr;
    bit       m_active [2];
    int       m_start  [2];
    int       m_stop   [2];
    int       m_cred   [2];
    bit       m_win    [2];

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_e = 0;
        m_sh_spin = '0;
        m_sh_set = '0;
        m_clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_start[i]  = 0;
            m_stop[i]   = -1;
            m_cred[i]   = CI;
            m_win[i]    = 1'b0;
        end
    endtask

    task automatic model_step();
        bit ps, pt;
        int cm;
        m_e++;
        m_sh_spin = {m_sh_spin[2:0], btn_spin};
        m_sh_set  = {m_sh_set[2:0], btn_set};
        ps = m_sh_spin[2] & ~m_sh_spin[3];
        pt = m_sh_set[2] & ~m_sh_set[3];
        m_clr = pt;
        for (int i = 0; i < 2; i++) begin
            cm = (i == 0) ? CM : CM12;
            if (pt) begin
                m_active[i] = 1'b0;
                m_stop[i]   = -1;
                m_cred[i]   = CI;
                m_win[i]    = 1'b0;
            end else if (!m_active[i]) begin
                if (ps && m_cred[i] > 0) begin
                    m_cred[i]--;
                    m_active[i] = 1'b1;
                    m_start[i]  = m_e;
                    m_stop[i]   = -1;
                    m_win[i]    = 1'b0;
                end
            end else if (m_stop[i] < 0) begin
                if (ps && (m_e - m_start[i] >= MS + 1))
                    m_stop[i] = m_e;
            end else if (m_e - m_stop[i] == 2 * G + 1) begin
                m_active[i] = 1'b0;
                if (digit[0] == digit[1] && digit[1] == digit[2]) begin
                    m_win[i]  = 1'b1;
                    m_cred[i] = imin(m_cred[i] + WP, cm);
                end else begin
                    m_win[i] = 1'b0;
                end
            end
        end
    endtask

    function automatic int exp_run(int i);
        int d;
        if (!m_active[i]) return 0;
        if (m_stop[i] < 0) return 7;
        d = m_e - m_stop[i];
        if (d < G) return 6;
        if (d < 2 * G) return 4;
        return 0;
    endfunction

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("m_run_a",  int'(run_a),  exp_run(0));
        chk("m_cred_a", int'(cred_a), m_cred[0]);
        chk("m_win_a",  int'(win_a),  int'(m_win[0]));
        chk("m_busy_a", int'(busy_a), int'(m_active[0]));
        chk("m_clr_a",  int'(clr_a),  int'(m_clr));
        chk("m_run_b",  int'(run_b),  exp_run(1));
        chk("m_cred_b", int'(cred_b), m_cred[1]);
        chk("m_win_b",  int'(win_b),  int'(m_win[1]));
        chk("m_busy_b", int'(busy_b), int'(m_active[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        @(negedge clk);
        if (rst_n) model_check();
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(bit sp, bit st);
        btn_spin = sp;
        btn_set  = st;
        tick();
        btn_spin = 1'b0;
        btn_set  = 1'b0;
    endtask

    task automatic set_digits(int a, int b, int c);
        digit[0] = digit_t'(a);
        digit[1] = digit_t'(b);
        digit[2] = digit_t'(c);
    endtask

    typedef struct {
        bit spin;
        bit set_;
        int wait_n;
        int d0, d1, d2;
        int run, clr, cred, cred12, win, busy;
    } vec_t;

    vec_t vq [$];

    function automatic vec_t mk(bit sp, bit st, int w, int d0, int d1, int d2,
                                int run, int clr, int cred, int cred12,
                                int wn, int bz);
        vec_t v;
        v.spin = sp; v.set_ = st; v.wait_n = w;
        v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.run = run; v.clr = clr; v.cred = cred; v.cred12 = cred12;
        v.win = wn; v.busy = bz;
        return v;
    endfunction

    initial begin
        set_digits(0, 0, 0);
        model_reset();

        vq.push_back(mk(1, 0,  3, 7, 7, 7, 7, 0,  4,  4, 0, 1));
        vq.push_back(mk(0, 0, 10, 7, 7, 7, 7, 0,  4,  4, 0, 1));
        vq.push_back(mk(1, 0,  3, 7, 7, 7, 6, 0,  4,  4, 0, 1));
        vq.push_back(mk(0, 0, 16, 7, 7, 7, 4, 0,  4,  4, 0, 1));
        vq.push_back(mk(0, 0, 15, 7, 7, 7, 4, 0,  4,  4, 0, 1));
        vq.push_back(mk(0, 0,  1, 7, 7, 7, 0, 0,  4,  4, 0, 1));
        vq.push_back(mk(0, 0,  1, 7, 7, 7, 0, 0, 14, 12, 1, 0));
        vq.push_back(mk(1, 0,  3, 1, 2, 3, 7, 0, 13, 11, 0, 1));
        vq.push_back(mk(1, 0,  3, 1, 2, 3, 7, 0, 13, 11, 0, 1));
        vq.push_back(mk(0, 0, 10, 1, 2, 3, 7, 0, 13, 11, 0, 1));
        vq.push_back(mk(1, 0,  3, 1, 2, 3, 6, 0, 13, 11, 0, 1));
        vq.push_back(mk(0, 0, 33, 1, 2, 3, 0, 0, 13, 11, 0, 0));
        vq.push_back(mk(1, 0,  3, 1, 2, 3, 7, 0, 12, 10, 0, 1));
        vq.push_back(mk(0, 0, 10, 1, 2, 3, 7, 0, 12, 10, 0, 1));
        vq.push_back(mk(1, 0,  3, 1, 2, 3, 6, 0, 12, 10, 0, 1));
        vq.push_back(mk(0, 0,  5, 1, 2, 3, 6, 0, 12, 10, 0, 1));
        vq.push_back(mk(1, 1,  3, 1, 2, 3, 0, 1,  5,  5, 0, 0));
        vq.push_back(mk(0, 0,  1, 1, 2, 3, 0, 0,  5,  5, 0, 0));
        vq.push_back(mk(1, 0,  3, 1, 2, 3, 7, 0,  4,  4, 0, 1));

        // Reset and release
        rst_n = 1'b0;
        ticks(3);
        rst_n = 1'b1;
        tick();
        chk("rst_run",  int'(run_a),  0);
        chk("rst_cred", int'(cred_a), CI);
        chk("rst_win",  int'(win_a),  0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_clr",  int'(clr_a),  0);

        foreach (vq[i]) begin
            set_digits(vq[i].d0, vq[i].d1, vq[i].d2);
            press(vq[i].spin, vq[i].set_);
            ticks(vq[i].wait_n - 1);
            chk($sformatf("v%0d_run", i),  int'(run_a),  vq[i].run);
            chk($sformatf("v%0d_clr", i),  int'(clr_a),  vq[i].clr);
            chk($sformatf("v%0d_cred", i), int'(cred_a), vq[i].cred);
            chk($sformatf("v%0d_sat", i),  int'(cred_b), vq[i].cred12);
            chk($sformatf("v%0d_win", i),  int'(win_a),  vq[i].win);
            chk($sformatf("v%0d_busy", i), int'(busy_a), vq[i].busy);
        end

        // Run credits down to zero with losing spins
        set_digits(1, 2, 3);
        press(0, 1);
        ticks(2);
        chk("drain_init", int'(cred_a), CI);
        for (int n = 0; n < 5; n++) begin
            press(1, 0);
            ticks(12);
            press(1, 0);
            ticks(34);
        end
        chk("drain_cred", int'(cred_a), 0);
        chk("drain_win",  int'(win_a),  0);
        press(1, 0);
        ticks(2);
        chk("nocred_run",  int'(run_a),  0);
        chk("nocred_busy", int'(busy_a), 0);
        ticks(5);
        chk("nocred_run2", int'(run_a),  0);
        chk("nocred_cred", int'(cred_a), 0);

        // Asynchronous reset in the middle of a spin
        press(0, 1);
        ticks(2);
        press(1, 0);
        ticks(4);
        chk("pre_rst_run", int'(run_a), 7);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_run",  int'(run_a),  0);
        chk("arst_cred", int'(cred_a), CI);
        chk("arst_win",  int'(win_a),  0);
        chk("arst_busy", int'(busy_a), 0);
        chk("arst_clr",  int'(clr_a),  0);
        chk("arst_runb", int'(run_b),  0);
        tick();
        rst_n = 1'b1;
        ticks(2);

        // Randomized button traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0) btn_spin = ~btn_spin;
            btn_set = ($urandom_range(249) == 0);
            if ($urandom_range(19) == 0) begin
                if ($urandom_range(1) == 0) begin
                    digit[0] = digit_t'($urandom_range(15));
                    digit[1] = digit[0];
                    digit[2] = digit[0];
                end else begin
                    digit[0] = digit_t'($urandom_range(15));
                    digit[1] = digit_t'($urandom_range(15));
                    digit[2] = digit_t'($urandom_range(15));
                end
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
